tick_gen: RTL and testbench
===========================

# tick_gen

Multi-channel programmable clock-enable generator for the parking controller. Each channel divides `clk` by a runtime-programmable half-period and produces a one-cycle `tick` strobe plus a 50 % duty square wave. Consumers include display blink, gate timers and the occupancy scan. All logic runs in the `clk` domain; outputs are enables, never used as clocks.

## Interface
- `NUM_CH`, 4, number of independent channels (1–16)
- `CNT_W`, 26, counter / half-period width in bits
- `DEF_HALF`, {NUM_CH{26'd20_000_000}}, packed NUM_CH×CNT_W reset half-periods; channel i uses slice [i*CNT_W +: CNT_W]
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low
- `en`  in  NUM_CH  per-channel run enable
- `cfg_valid`  in  1  half-period write request
- `cfg_ready`  out  1  write can be accepted this cycle
- `cfg_ch`  in  $clog2(NUM_CH) (min 1)  target channel
- `cfg_half`  in  CNT_W  new half-period in cycles
- `tick`  out  NUM_CH  one-cycle strobe per half-period
- `sq`  out  NUM_CH  square wave, toggles with each tick
- `align`  in  1  phase-align all channels (only with `TICK_GEN_ALIGN_EN`)

## Operation
- Reset (`reset`=0 at a rising edge): every `cnt`=0, `half`=DEF_HALF slice, `pending`=0, `tick`=0, `sq`=0. Reset has priority over everything, including mid-count and pending writes.
- Channel with `en`=1: if `cnt`==`half`-1 → `cnt`←0, `sq`←~`sq`, `tick`←1; else `cnt`←`cnt`+1, `tick`←0.
- Channel with `en`=0: `cnt` and `sq` hold, `tick`←0.
- Effective half-period 0 is clamped to 1, so `tick` is high every cycle and `sq` toggles every cycle.
- Config handshake: transfer when `cfg_valid`&&`cfg_ready`. `cfg_ready`=~`pending[cfg_ch]` (combinational). `cfg_ch`≥NUM_CH: `cfg_ready`=1, write dropped.
- Accepted write stores `cfg_half` in the channel's shadow register and sets `pending`.
- Pending value loads into `half` at that channel's next wrap (glitch-free; the current half-period completes at the old value), clearing `pending`. If the channel is disabled, it loads on the next cycle with `cnt`←0.
- A write accepted in the same cycle as a wrap applies at the following wrap.

## Timing
- `tick` is registered: high for exactly one cycle, in the cycle after the edge where `cnt`==`half`-1.
- Tick spacing = `half` cycles. `sq` period = 2×`half` cycles.
- First tick after reset release with `en`=1 occurs `half` cycles later.
- `en` rising edge: counting resumes on the same edge. No tick is lost or duplicated.

## Configuration
- `TICK_GEN_ALIGN_EN` defined: `align` port exists. `align`=1 at an edge sets every `cnt`←0, `sq`←0 and `tick`←0, and applies all pending writes. Reset still takes priority over `align`; `align` takes priority over wrap and `en`.
- Macro undefined: no `align` port; channels are aligned only by reset.

## Structure
- Package `tick_pkg`: `CNT_W` default, the default-half constants for 1 Hz / 2 Hz / 4 Hz at 40 MHz, and the `ch_cfg_t` struct {half, shadow, pending}.
- Sub-module `tick_channel`: one counter, shadow register and tick/sq register, instantiated NUM_CH times by a generate loop. The top level holds only the config decode and ready mux.

## Test plan
- Reset defaults: DEF_HALF=3 for all channels, `en`=all 1 → ticks at cycles 3, 6, 9 after release; `sq` toggles at the same cycles; all outputs 0 during reset.
- Runtime reprogram: ch1 half=4 mid-period, write half=2 → the current period finishes at 4, then ticks every 2 cycles. A second write before the wrap sees `cfg_ready`=0.
- Enable gating: drop `en[0]` for 5 cycles at `cnt`=1 → the tick is delayed by exactly 5 cycles and `sq` holds.
- Boundaries: half=0 and half=1 → `tick` is constantly 1. `cfg_ch`=NUM_CH write is accepted and has no effect.
- Reset mid-operation: assert `reset` while `pending`=1 and `sq`=1 → all state returns to DEF_HALF and the pending write is discarded.
- With `TICK_GEN_ALIGN_EN`: channels with halves 3 and 5, pulse `align` → both ticks coincide at cycle 15 after `align`.

Source files
------------

// File: rtl/tick_pkg.sv
// tick_pkg: shared constants and types for the tick_gen clock-enable generator.
//
// Contents:
//   CNT_W_DEF            default counter / half-period width
//   CLK_HZ               system clock frequency the default halves are derived from
//   half_for_hz()        half-period in clk cycles for a given output frequency
//   HALF_1HZ/2HZ/4HZ     default half-periods for 1 Hz, 2 Hz and 4 Hz at 40 MHz
//   ch_cfg_t             per-channel configuration record {half, shadow, pending}
//
// ch_cfg_t is sized from CNT_W_DEF, so tick_channel instances must use CNT_W == CNT_W_DEF.

package tick_pkg;

    localparam int unsigned CNT_W_DEF = 26;
    localparam int unsigned CLK_HZ    = 40_000_000;

    // One full output period is 2 half-periods, hence the factor of two.
    function automatic int unsigned half_for_hz(input int unsigned clk_hz,
                                                input int unsigned hz);
        return clk_hz / (2 * hz);
    endfunction

    localparam int unsigned HALF_1HZ = half_for_hz(CLK_HZ, 1);
    localparam int unsigned HALF_2HZ = half_for_hz(CLK_HZ, 2);
    localparam int unsigned HALF_4HZ = half_for_hz(CLK_HZ, 4);

    typedef struct packed {
        logic [CNT_W_DEF-1:0] half;     // active half-period
        logic [CNT_W_DEF-1:0] shadow;   // written value waiting for the next wrap
        logic                 pending;  // shadow holds a value not yet applied
    } ch_cfg_t;

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one divider channel of tick_gen.
//
// Counts enabled clk cycles; every half-period it emits a one-cycle tick and toggles sq.
// A new half-period is written into a shadow register and applied only at the next wrap
// (or straight away when the channel is idle), so a running period is never cut short.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-low reset
//   en        in   run enable; counter and sq hold while low
//   align     in   restart the channel at phase 0 and apply any pending write
//   cfg_we    in   store cfg_half in the shadow register and mark it pending
//   cfg_half  in   new half-period in cycles (0 behaves as 1)
//   tick      out  registered one-cycle strobe per half-period
//   sq        out  registered square wave, toggles with each tick
//   pending   out  a shadow value is waiting to be applied

module tick_channel
    import tick_pkg::*;
#(
    parameter int unsigned      CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(HALF_1HZ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             align,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             tick,
    output logic             sq,
    output logic             pending
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_eff;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             wrap;
    ch_cfg_t          cfg_q, cfg_d;

    // A half-period of 0 would never match cnt == half-1; treat it as 1.
    assign half_eff = (cfg_q.half == '0) ? CNT_W'(1) : cfg_q.half;
    assign wrap     = en && (cnt_q == half_eff - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
            cfg_q  <= '{half: DEF_HALF, shadow: '0, pending: 1'b0};
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
            cfg_q  <= cfg_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        sq_d   = sq_q;
        tick_d = 1'b0;
        cfg_d  = cfg_q;

        if (align) begin
            cnt_d = '0;
            sq_d  = 1'b0;
            if (cfg_q.pending) begin
                cfg_d.half    = cfg_q.shadow;
                cfg_d.pending = 1'b0;
            end
        end else if (wrap) begin
            cnt_d  = '0;
            sq_d   = ~sq_q;
            tick_d = 1'b1;
            if (cfg_q.pending) begin
                cfg_d.half    = cfg_q.shadow;
                cfg_d.pending = 1'b0;
            end
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (cfg_q.pending) begin
            // Idle channel: nothing to finish, so apply now and start from phase 0.
            cnt_d         = '0;
            cfg_d.half    = cfg_q.shadow;
            cfg_d.pending = 1'b0;
        end

        // The top only raises cfg_we when pending is clear, so this never overwrites a value
        // that is being applied on the same edge; a write coinciding with a wrap waits for
        // the following wrap.
        if (cfg_we) begin
            cfg_d.shadow  = cfg_half;
            cfg_d.pending = 1'b1;
        end
    end

    assign tick    = tick_q;
    assign sq      = sq_q;
    assign pending = cfg_q.pending;

endmodule

// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable clock-enable generator.
//
// Each channel divides clk by a runtime-programmable half-period and produces a one-cycle
// tick strobe plus a 50 % duty square wave. Outputs are enables, never clocks.
// This level only decodes config writes and muxes cfg_ready; the counting lives in
// tick_channel, one instance per channel.
//
// Build option: define TICK_GEN_ALIGN_EN to add the align port, which restarts all channels
// at phase 0 and applies all pending writes. Without it, channels are aligned only by reset.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low reset
//   en         in   per-channel run enable
//   cfg_valid  in   half-period write request
//   cfg_ready  out  write can be accepted this cycle (combinational)
//   cfg_ch     in   target channel; out-of-range channels accept and drop the write
//   cfg_half   in   new half-period in cycles
//   align      in   phase-align all channels (TICK_GEN_ALIGN_EN only)
//   tick       out  per-channel one-cycle strobe per half-period
//   sq         out  per-channel square wave

module tick_gen
    import tick_pkg::*;
#(
    parameter int unsigned               NUM_CH   = 4,
    parameter int unsigned               CNT_W    = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0]   DEF_HALF = {NUM_CH{CNT_W'(HALF_1HZ)}}
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_CH-1:0]                          en,
    input  logic                                       cfg_valid,
    output logic                                       cfg_ready,
    input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                           cfg_half,
`ifdef TICK_GEN_ALIGN_EN
    input  logic                                       align,
`endif
    output logic [NUM_CH-1:0]                          tick,
    output logic [NUM_CH-1:0]                          sq
);

    localparam int unsigned CH_W    = $clog2(NUM_CH > 1 ? NUM_CH : 2);
    localparam int unsigned CH_SPAN = 1 << CH_W;

    logic [NUM_CH-1:0]  pending;
    logic [NUM_CH-1:0]  cfg_we;
    logic [CH_SPAN-1:0] pending_ext;
    logic               align_int;

`ifdef TICK_GEN_ALIGN_EN
    assign align_int = align;
`else
    assign align_int = 1'b0;
`endif

    // Pad pending out to every encodable channel index; the unused slots read as "not
    // pending", which makes writes to nonexistent channels always ready.
    always_comb begin
        pending_ext             = '0;
        pending_ext[NUM_CH-1:0] = pending;
    end

    assign cfg_ready = ~pending_ext[cfg_ch];

    // Out-of-range cfg_ch matches no channel, so the transfer completes with no effect.
    always_comb begin
        cfg_we = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_we[i] = cfg_valid & cfg_ready;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF[g*CNT_W +: CNT_W])
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en[g]),
            .align    (align_int),
            .cfg_we   (cfg_we[g]),
            .cfg_half (cfg_half),
            .tick     (tick[g]),
            .sq       (sq[g]),
            .pending  (pending[g])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Testbench for tick_gen: directed scenarios plus randomized traffic, checked against a
// cycle-level reference model through an expectation queue drained by a separate monitor.

module tb_tick_gen;

    localparam int unsigned NCH = 3;   // not a power of two, so cfg_ch == NCH is encodable
    localparam int unsigned CW  = 26;
    localparam int unsigned CHW = 2;
    localparam int          DEF = 3;
    localparam logic [NCH*CW-1:0] DEFH = {NCH{26'd3}};

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] en;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_half;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
`ifdef TICK_GEN_ALIGN_EN
    logic           align;
`endif

    tick_gen #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .DEF_HALF (DEFH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
`ifdef TICK_GEN_ALIGN_EN
        .align     (align),
`endif
        .tick      (tick),
        .sq        (sq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           ready;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sq;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: each channel tracks how many enabled cycles remain until its next
    // tick, plus the programmed half-period and any write awaiting the next period boundary.
    int m_half[NCH];
    int m_left[NCH];
    int m_shadow[NCH];
    bit m_sq[NCH];
    bit m_tick[NCH];
    bit m_pend[NCH];

    function automatic int period_of(input int h);
        return (h < 1) ? 1 : h;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_half[c]   = DEF;
            m_left[c]   = period_of(DEF);
            m_shadow[c] = 0;
            m_sq[c]     = 1'b0;
            m_tick[c]   = 1'b0;
            m_pend[c]   = 1'b0;
        end
    endtask

    // Apply one rising edge to the model with the inputs held during the cycle.
    task automatic model_edge(input logic rst, input logic [NCH-1:0] e, input logic v,
                              input int ch, input int h, input logic al);
        bit accept;
        if (!rst) begin
            model_reset();
            return;
        end
        accept = v && (ch < NCH) && !m_pend[ch < NCH ? ch : 0];
        for (int c = 0; c < NCH; c++) begin
            m_tick[c] = 1'b0;
            if (al) begin
                if (m_pend[c]) begin
                    m_half[c] = m_shadow[c];
                    m_pend[c] = 1'b0;
                end
                m_left[c] = period_of(m_half[c]);
                m_sq[c]   = 1'b0;
            end else if (e[c]) begin
                m_left[c] = m_left[c] - 1;
                if (m_left[c] == 0) begin
                    m_tick[c] = 1'b1;
                    m_sq[c]   = ~m_sq[c];
                    if (m_pend[c]) begin
                        m_half[c] = m_shadow[c];
                        m_pend[c] = 1'b0;
                    end
                    m_left[c] = period_of(m_half[c]);
                end
            end else if (m_pend[c]) begin
                m_half[c] = m_shadow[c];
                m_pend[c] = 1'b0;
                m_left[c] = period_of(m_half[c]);
            end
        end
        if (accept) begin
            m_shadow[ch] = h;
            m_pend[ch]   = 1'b1;
        end
    endtask

    // One clock cycle: drive inputs, queue what the DUT must show during this cycle, then
    // advance the model across the coming edge.
    task automatic step(input logic rst, input logic [NCH-1:0] e, input logic v,
                        input int ch, input int h, input logic al);
        exp_t x;
        @(posedge clk);
        #1;
        reset     = rst;
        en        = e;
        cfg_valid = v;
        cfg_ch    = CHW'(ch);
        cfg_half  = CW'(h);
`ifdef TICK_GEN_ALIGN_EN
        align     = al;
`endif
        x.ready = (ch >= NCH) ? 1'b1 : ~m_pend[ch];
        for (int c = 0; c < NCH; c++) begin
            x.tick[c] = m_tick[c];
            x.sq[c]   = m_sq[c];
        end
        q.push_back(x);
        model_edge(rst, e, v, ch, h, al);
    endtask

    task automatic idle(input int n, input logic [NCH-1:0] e);
        for (int i = 0; i < n; i++) step(1'b1, e, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic wr(input int ch, input int h, input logic [NCH-1:0] e);
        step(1'b1, e, 1'b1, ch, h, 1'b0);
    endtask

    // Monitor: compare the DUT against the oldest expectation on every falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (tick !== x.tick) begin
                    errors++;
                    $display("FAIL tick @%0t: got %b want %b", $time, tick, x.tick);
                end
                checks++;
                if (sq !== x.sq) begin
                    errors++;
                    $display("FAIL sq @%0t: got %b want %b", $time, sq, x.sq);
                end
                checks++;
                if (cfg_ready !== x.ready) begin
                    errors++;
                    $display("FAIL cfg_ready @%0t ch=%0d: got %b want %b", $time, cfg_ch,
                             cfg_ready, x.ready);
                end
            end
        end
    end

    initial begin
        logic [NCH-1:0] e;
        reset     = 1'b0;
        en        = '1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_half  = '0;
`ifdef TICK_GEN_ALIGN_EN
        align     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        model_reset();

        // Reset defaults, then free running at half=3 on every channel.
        for (int i = 0; i < 3; i++) step(1'b0, '1, 1'b0, 0, 0, 1'b0);
        idle(12, '1);

        // Runtime reprogram of ch1: 4 first, then 2 mid-period with a refused second write.
        wr(1, 4, '1);
        idle(4, '1);
        idle(2, '1);
        wr(1, 2, '1);
        wr(1, 7, '1);
        idle(10, '1);

        // Enable gating: hold ch0 for 5 cycles part-way through a period.
        idle(1, '1);
        idle(5, 3'b110);
        idle(8, '1);

        // Half-periods 0 and 1 tick every cycle; an idle channel applies a write at once.
        wr(2, 0, '1);
        idle(6, '1);
        wr(2, 1, 3'b011);
        idle(2, 3'b011);
        idle(5, '1);

        // Write to a nonexistent channel: always ready, no effect.
        wr(3, 5, '1);
        idle(6, '1);

        // Reset while a write is pending and sq is high.
        wr(0, 6, '1);
        step(1'b0, '1, 1'b0, 0, 0, 1'b0);
        idle(10, '1);

`ifdef TICK_GEN_ALIGN_EN
        // Align channels with halves 3 and 5: ticks coincide 15 cycles later.
        wr(0, 3, '1);
        wr(1, 5, '1);
        idle(8, '1);
        step(1'b1, '1, 1'b0, 0, 0, 1'b1);
        idle(20, '1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic rst, v, al;
            int   ch, h;
            rst = ($urandom_range(0, 299) != 0);
            for (int c = 0; c < NCH; c++) e[c] = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 2) == 0);
            ch = $urandom_range(0, 3);
            h  = $urandom_range(0, 7);
`ifdef TICK_GEN_ALIGN_EN
            al = ($urandom_range(0, 99) == 0);
`else
            al = 1'b0;
`endif
            step(rst, e, v, ch, h, al);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
